// File: rtl/egress_drain_counter_if.sv
// rtl/egress_drain_counter_if.sv - FIFO, egress stream and counter-query signals of egress_drain_counter
// dest_err/err_count exist only when CHECK_DEST_EN is defined.
interface egress_drain_counter_if #(
   parameter int DW = 10,
   parameter int CW = 5
);
   logic [DW-1:0] fifo_data_out4, fifo_data_out5, fifo_data_out6, fifo_data_out7;
   logic          fifo_empty4, fifo_empty5, fifo_empty6, fifo_empty7;
   logic          pop4, pop5, pop6, pop7;
   logic          out_ready;
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic [1:0]    chan_out;
   logic          IDLE;
   logic          req;
   logic [1:0]    idx;
   logic [CW-1:0] contador_out;
   logic          valid_contador;
`ifdef CHECK_DEST_EN
   logic          dest_err;
   logic [7:0]    err_count;
`endif

   modport slave (
      input  fifo_data_out4, fifo_data_out5, fifo_data_out6, fifo_data_out7,
      input  fifo_empty4, fifo_empty5, fifo_empty6, fifo_empty7,
      output pop4, pop5, pop6, pop7,
      input  out_ready,
      output data_out, valid_out, chan_out,
      input  IDLE, req, idx,
`ifdef CHECK_DEST_EN
      output dest_err, err_count,
`endif
      output contador_out, valid_contador
   );

   modport master (
      output fifo_data_out4, fifo_data_out5, fifo_data_out6, fifo_data_out7,
      output fifo_empty4, fifo_empty5, fifo_empty6, fifo_empty7,
      input  pop4, pop5, pop6, pop7,
      output out_ready,
      input  data_out, valid_out, chan_out,
      output IDLE, req, idx,
`ifdef CHECK_DEST_EN
      input  dest_err, err_count,
`endif
      input  contador_out, valid_contador
   );
endinterface

// File: rtl/egress_drain_counter.sv
// rtl/egress_drain_counter.sv - round-robin drain of FIFOs 4..7 into one egress stream with per-channel counters
// Optional destination-class checking is built when CHECK_DEST_EN is defined.
module egress_drain_counter #(
   parameter int DW = 10,
   parameter int CW = 5
) (
   input  logic clk,
   input  logic reset,
   egress_drain_counter_if.slave bus
);
   localparam logic [0:0] S_WAIT  = 1'b0;
   localparam logic [0:0] S_DRAIN = 1'b1;

   logic [0:0]    r_state;
   logic [1:0]    r_rr;
   logic          r_inflight;
   logic [1:0]    r_inflight_ch;
   logic          r_skid_v;
   logic [DW-1:0] r_skid_data;
   logic [1:0]    r_skid_ch;
   logic          r_valid;
   logic [DW-1:0] r_data;
   logic [1:0]    r_chan;
   logic [CW-1:0] r_cnt [4];
   logic          r_vcnt;
   logic [CW-1:0] r_cnt_out;

   logic [3:0]    w_empty;
   logic [DW-1:0] w_fifo_data [4];
   logic          w_out_free;
   logic          w_xfer;
   logic          w_grant_v;
   logic [1:0]    w_grant_ch;
   logic [1:0]    w_cand;
   logic          w_pop_en;
   logic [3:0]    w_pop;
   logic [0:0]    w_state_nxt;
   logic          w_query;

   assign w_empty        = {bus.fifo_empty7, bus.fifo_empty6, bus.fifo_empty5, bus.fifo_empty4};
   assign w_fifo_data[0] = bus.fifo_data_out4;
   assign w_fifo_data[1] = bus.fifo_data_out5;
   assign w_fifo_data[2] = bus.fifo_data_out6;
   assign w_fifo_data[3] = bus.fifo_data_out7;
   assign w_out_free     = !r_valid || bus.out_ready;
   assign w_xfer         = r_valid && bus.out_ready;
   assign w_query        = bus.req && bus.IDLE;

   // r_rr holds the first channel to try: one past the last grant
   always_comb begin
      w_grant_v  = 1'b0;
      w_grant_ch = r_rr;
      w_cand     = r_rr;
      for (int i = 0; i < 4; i++) begin
         w_cand = r_rr + 2'(i);
         if (!w_grant_v && !w_empty[w_cand]) begin
            w_grant_v  = 1'b1;
            w_grant_ch = w_cand;
         end
      end
   end

   assign w_pop_en = (r_state == S_DRAIN) && w_grant_v && !r_skid_v && w_out_free;
   assign w_pop    = w_pop_en ? (4'b0001 << w_grant_ch) : 4'b0000;
   assign bus.pop4 = w_pop[0];
   assign bus.pop5 = w_pop[1];
   assign bus.pop6 = w_pop[2];
   assign bus.pop7 = w_pop[3];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_WAIT:  if (w_empty != 4'hF) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_empty == 4'hF && !r_inflight && !r_skid_v && !r_valid) w_state_nxt = S_WAIT;
         default: w_state_nxt = S_WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_WAIT;
         r_rr          <= 2'd0;
         r_inflight    <= 1'b0;
         r_inflight_ch <= 2'd0;
         r_skid_v      <= 1'b0;
         r_skid_data   <= '0;
         r_skid_ch     <= 2'd0;
         r_valid       <= 1'b0;
         r_data        <= '0;
         r_chan        <= 2'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_pop_en;
         if (w_pop_en) begin
            r_inflight_ch <= w_grant_ch;
            r_rr          <= w_grant_ch + 2'd1;
         end
         // A word arriving while the output is stalled parks in the skid; pops stop until it drains
         if (w_out_free) begin
            if (r_skid_v) begin
               r_data   <= r_skid_data;
               r_chan   <= r_skid_ch;
               r_valid  <= 1'b1;
               r_skid_v <= 1'b0;
            end else if (r_inflight) begin
               r_data  <= w_fifo_data[r_inflight_ch];
               r_chan  <= r_inflight_ch;
               r_valid <= 1'b1;
            end else begin
               r_valid <= 1'b0;
            end
         end else if (r_inflight) begin
            r_skid_data <= w_fifo_data[r_inflight_ch];
            r_skid_ch   <= r_inflight_ch;
            r_skid_v    <= 1'b1;
         end
      end
   end

   // Query samples counters before this cycle's increment
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
         r_vcnt    <= 1'b0;
         r_cnt_out <= '0;
      end else begin
         if (w_xfer) r_cnt[r_chan] <= r_cnt[r_chan] + 1'b1;
         r_vcnt    <= w_query;
         r_cnt_out <= w_query ? r_cnt[bus.idx] : '0;
      end
   end

   assign bus.data_out       = r_data;
   assign bus.valid_out      = r_valid;
   assign bus.chan_out       = r_chan;
   assign bus.contador_out   = r_cnt_out;
   assign bus.valid_contador = r_vcnt;

`ifdef CHECK_DEST_EN
   logic       r_dest_err;
   logic [7:0] r_err_cnt;
   logic       w_dest_mis;

   assign w_dest_mis = w_xfer && (r_data[DW-1:DW-2] != r_chan);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dest_err <= 1'b0;
         r_err_cnt  <= 8'd0;
      end else begin
         r_dest_err <= w_dest_mis;
         if (w_dest_mis && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign bus.dest_err  = r_dest_err;
   assign bus.err_count = r_err_cnt;
`endif
endmodule

// File: tb/tb_egress_drain_counter.sv
// tb/tb_egress_drain_counter.sv - randomized bench for egress_drain_counter against a queue-based reference model
// Covers the CHECK_DEST_EN build when that macro is defined.
module tb_egress_drain_counter;
   localparam int DW = 10;
   localparam int CW = 5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   egress_drain_counter_if #(.DW(DW), .CW(CW)) bus_if();
   egress_drain_counter #(.DW(DW), .CW(CW)) dut (.clk(clk), .reset(reset), .bus(bus_if));

   logic [DW-1:0] fdat [4];
   logic          femp [4];
   assign bus_if.fifo_data_out4 = fdat[0];
   assign bus_if.fifo_data_out5 = fdat[1];
   assign bus_if.fifo_data_out6 = fdat[2];
   assign bus_if.fifo_data_out7 = fdat[3];
   assign bus_if.fifo_empty4    = femp[0];
   assign bus_if.fifo_empty5    = femp[1];
   assign bus_if.fifo_empty6    = femp[2];
   assign bus_if.fifo_empty7    = femp[3];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: FIFO contents, expected per-channel delivery order, counters
   logic [DW-1:0] fq [4][$];
   logic [DW-1:0] sb [4][$];
   int            cnt_m [4];
   int            ptr_m;
   int            pend_pop_ch;
   bit            pop_h1, pop_h2, stall_h1, prev_valid;
   int            pop_h1_ch, pop_h2_ch;
   logic [DW-1:0] pop_h1_w, pop_h2_w, prev_data;
   logic [1:0]    prev_chan;
   bit            q_pend;
   int            q_val;
   bit            derr_pend;
   int            err_m;
   int            dest_pulses;
   int            pop_count [4];
   int            xfer_chans [$];
   int            cyc, pop0_first, pop0_last;

   logic          drv_ready, drv_req, drv_idle;
   logic [1:0]    drv_idx;

   task automatic reset_model(input bit flush);
      for (int c = 0; c < 4; c++) begin
         if (flush) fq[c].delete();
         sb[c].delete();
         cnt_m[c] = 0;
      end
      ptr_m = 0; pend_pop_ch = -1;
      pop_h1 = 0; pop_h2 = 0; stall_h1 = 0; prev_valid = 0;
      q_pend = 0; derr_pend = 0; err_m = 0;
   endtask

   task automatic push(input int ch, input logic [DW-1:0] w);
      fq[ch].push_back(w);
      sb[ch].push_back(w);
   endtask

   task automatic chk_zero();
      check("rst_pops", 32'({bus_if.pop7, bus_if.pop6, bus_if.pop5, bus_if.pop4}), 0);
      check("rst_valid", 32'(bus_if.valid_out), 0);
      check("rst_data", 32'(bus_if.data_out), 0);
      check("rst_chan", 32'(bus_if.chan_out), 0);
      check("rst_vcnt", 32'(bus_if.valid_contador), 0);
      check("rst_cnt", 32'(bus_if.contador_out), 0);
   endtask

   task automatic sample();
      logic [3:0] p;
      int ch, exp_ch, qv_next;
      bit mis;
      p = {bus_if.pop7, bus_if.pop6, bus_if.pop5, bus_if.pop4};
      ch = -1;
      check("pop_onehot", 32'($countones(p) <= 1), 1);
      for (int c = 0; c < 4; c++) if (p[c]) ch = c;
      if (ch >= 0) begin
         check("pop_nonempty", 32'(femp[ch]), 0);
         check("pop_outfree", 32'(!(bus_if.valid_out && !bus_if.out_ready)), 1);
         exp_ch = -1;
         for (int k = 0; k < 4; k++)
            if (exp_ch < 0 && !femp[(ptr_m + k) % 4]) exp_ch = (ptr_m + k) % 4;
         check("rr_grant", 32'(ch), 32'(exp_ch));
         ptr_m = (ch + 1) % 4;
         pend_pop_ch = ch;
         pop_count[ch]++;
         if (ch == 0) begin
            if (pop0_first < 0) pop0_first = cyc;
            pop0_last = cyc;
         end
      end
      if (stall_h1) begin
         check("hold_valid", 32'(bus_if.valid_out), 1);
         check("hold_data", 32'(bus_if.data_out), 32'(prev_data));
         check("hold_chan", 32'(bus_if.chan_out), 32'(prev_chan));
      end
      if (pop_h2 && !stall_h1) begin
         check("lat_valid", 32'(bus_if.valid_out), 1);
         check("lat_chan", 32'(bus_if.chan_out), 32'(pop_h2_ch));
         check("lat_data", 32'(bus_if.data_out), 32'(pop_h2_w));
      end
      check("q_valid", 32'(bus_if.valid_contador), 32'(q_pend));
      if (q_pend) check("q_value", 32'(bus_if.contador_out), 32'(q_val));
      qv_next = cnt_m[drv_idx];
`ifdef CHECK_DEST_EN
      check("dest_err", 32'(bus_if.dest_err), 32'(derr_pend));
      check("err_count", 32'(bus_if.err_count), 32'(err_m));
      if (bus_if.dest_err) dest_pulses++;
`endif
      mis = 0;
      if (bus_if.valid_out && bus_if.out_ready) begin
         if (sb[bus_if.chan_out].size() == 0) check("xfer_unexpected", 1, 0);
         else check("xfer_data", 32'(bus_if.data_out), 32'(sb[bus_if.chan_out].pop_front()));
         xfer_chans.push_back(int'(bus_if.chan_out));
         cnt_m[bus_if.chan_out] = (cnt_m[bus_if.chan_out] + 1) % (1 << CW);
         mis = (bus_if.data_out[DW-1:DW-2] != bus_if.chan_out);
      end
      derr_pend = mis;
      if (mis && err_m < 255) err_m++;
      q_pend = drv_req && drv_idle;
      q_val  = qv_next;
      pop_h2 = pop_h1; pop_h2_ch = pop_h1_ch; pop_h2_w = pop_h1_w;
      pop_h1 = (ch >= 0);
      if (ch >= 0) begin pop_h1_ch = ch; pop_h1_w = fq[ch][0]; end
      stall_h1   = bus_if.valid_out && !bus_if.out_ready;
      prev_valid = bus_if.valid_out;
      prev_data  = bus_if.data_out;
      prev_chan  = bus_if.chan_out;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      cyc++;
      if (pend_pop_ch >= 0) begin
         fdat[pend_pop_ch] = fq[pend_pop_ch].pop_front();
         pend_pop_ch = -1;
      end
      for (int c = 0; c < 4; c++) femp[c] = (fq[c].size() == 0);
      bus_if.out_ready = drv_ready;
      bus_if.req       = drv_req;
      bus_if.IDLE      = drv_idle;
      bus_if.idx       = drv_idx;
      @(negedge clk);
      if (reset) chk_zero();
      else sample();
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #1 reset_model(1);
      chk_zero();
      cycle();
      cycle();
      reset = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      bit done;
      n = 0;
      done = 0;
      drv_ready = 1'b1;
      while (!done && n < budget) begin
         cycle();
         n++;
         done = !bus_if.valid_out && (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() == 0);
      end
      check("drain_done", 32'(done), 1);
   endtask

   task automatic query(input logic idle, input logic [1:0] ix);
      drv_idle = idle; drv_req = 1'b1; drv_idx = ix;
      cycle();
      drv_req = 1'b0;
      cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      drv_ready = 1'b1; drv_req = 1'b0; drv_idle = 1'b0; drv_idx = 2'd0;
      bus_if.out_ready = 1'b1; bus_if.req = 1'b0; bus_if.IDLE = 1'b0; bus_if.idx = 2'd0;
      for (int c = 0; c < 4; c++) begin fdat[c] = '0; femp[c] = 1'b1; pop_count[c] = 0; end
      cyc = 0; pop0_first = -1; pop0_last = -1; dest_pulses = 0;
      reset_model(1);

      // Reset held with all FIFOs loaded: no pops, outputs zero
      for (int c = 0; c < 4; c++) for (int i = 0; i < 3; i++) fq[c].push_back(DW'(c * 256 + i));
      repeat (4) cycle();
      reset_model(1);
      for (int i = 0; i < 5; i++) push(0, 10'h001);
      cycle();
      reset = 1'b0;
      pop_count[0] = 0;
      xfer_chans.delete();
      drain(100);
      check("p1_pops", 32'(pop_count[0]), 5);
      check("p1_pop_run", 32'(pop0_last - pop0_first + 1), 5);
      check("p1_xfers", 32'(xfer_chans.size()), 5);

      // Round robin with a 3-cycle backpressure window
      do_reset();
      for (int i = 0; i < 4; i++) for (int c = 0; c < 4; c++) push(c, DW'(c * 256 + 1 + i));
      xfer_chans.delete();
      repeat (6) cycle();
      drv_ready = 1'b0;
      repeat (3) cycle();
      drain(100);
      check("rr_count", 32'(xfer_chans.size()), 16);
      for (int i = 0; i < xfer_chans.size() && i < 16; i++) check("rr_order", 32'(xfer_chans[i]), 32'(i % 4));
      query(1'b1, 2'd2);
      check("q_idx2_valid", 32'(bus_if.valid_contador), 1);
      check("q_idx2_value", 32'(bus_if.contador_out), 4);
      query(1'b0, 2'd2);
      check("q_busy_valid", 32'(bus_if.valid_contador), 0);

      // Counter wrap: 33 words through FIFO5
      do_reset();
      for (int i = 0; i < 33; i++) push(1, DW'(256 + i));
      drain(300);
      query(1'b1, 2'd1);
      check("wrap_value", 32'(bus_if.contador_out), 1);

`ifdef CHECK_DEST_EN
      do_reset();
      dest_pulses = 0;
      push(0, 10'h201);
      push(0, 10'h005);
      push(1, 10'h105);
      drain(100);
      cycle();
      check("dest_pulses", 32'(dest_pulses), 1);
      check("dest_errcnt", 32'(bus_if.err_count), 1);
`endif

      // Randomized traffic with a mid-stream reset
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         int c;
         logic [1:0] cls;
         c = int'($urandom_range(0, 3));
         if ($urandom_range(0, 99) < 45 && fq[c].size() < 12) begin
            cls = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'(c);
            push(c, {cls, 8'($urandom)});
         end
         drv_ready = ($urandom_range(0, 99) < 70);
         drv_req   = ($urandom_range(0, 99) < 20);
         drv_idle  = ($urandom_range(0, 99) < 60);
         drv_idx   = 2'($urandom);
         if (n == 700) do_reset();
         else cycle();
      end
      drv_req = 1'b0;
      drain(500);
      for (int c = 0; c < 4; c++) begin
         query(1'b1, 2'(c));
         check("final_cnt", 32'(bus_if.contador_out), 32'(cnt_m[c]));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
